// File: rtl/cp0.sv
// Coprocessor-0: SR/Cause/EPC/PRId registers, interrupt and exception arbitration for the
// five-stage pipeline; IRQ redirects fetch, EPC feeds eret, rdata serves mfc0.
module cp0 #(
  parameter logic [31:0] PRID = 32'h4D49_5053
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] PC_M,
  input  logic        BD_M,
  input  logic [4:0]  ExcCode_M,
  input  logic [5:0]  HWInt,
  input  logic        we_M,
  input  logic [4:0]  addr_M,
  input  logic [31:0] wdata_M,
  input  logic        eret_M,
  output logic [31:0] rdata,
  output logic [31:0] EPC,
  output logic        IRQ
);

  localparam logic [4:0] AddrSr    = 5'd12;
  localparam logic [4:0] AddrCause = 5'd13;
  localparam logic [4:0] AddrEpc   = 5'd14;
  localparam logic [4:0] AddrPrid  = 5'd15;

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  logic [4:0]  exc_code_q, exc_code_d;
  logic [31:0] epc_q, epc_d;

  logic        int_req;
  logic        exc_req;
  logic [31:0] pc_eff;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  // HWInt is used live, not the registered IP copy, so interrupts are seen the same cycle.
  assign int_req = (|(HWInt & im_q)) & ie_q & ~exl_q;
  assign exc_req = (ExcCode_M != 5'd0) & ~exl_q;
  assign IRQ     = int_req | exc_req;

  assign pc_eff = BD_M ? (PC_M - 32'd4) : PC_M;

  assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
  assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_code_q, 2'b0};
  assign EPC        = epc_q;

  always_comb begin
    rdata = 32'd0;
    case (addr_M)
      AddrSr:    rdata = sr_word;
      AddrCause: rdata = cause_word;
      AddrEpc:   rdata = epc_q;
      AddrPrid:  rdata = PRID;
      default:   rdata = 32'd0;
    endcase
  end

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = HWInt;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    if (IRQ) begin
      exl_d      = 1'b1;
      bd_d       = BD_M;
      exc_code_d = int_req ? 5'd0 : ExcCode_M;
      epc_d      = pc_eff & 32'hFFFF_FFFC;
    end else begin
      if (we_M) begin
        if (addr_M == AddrSr) begin
          im_d  = wdata_M[15:10];
          exl_d = wdata_M[1];
          ie_d  = wdata_M[0];
        end else if (addr_M == AddrEpc) begin
          epc_d = wdata_M & 32'hFFFF_FFFC;
        end
      end
      // eret wins over an mtc0 to EXL; the written IM/IE still land.
      if (eret_M) exl_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      im_q       <= 6'd0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= 6'd0;
      exc_code_q <= 5'd0;
      epc_q      <= 32'd0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Bench for cp0: directed scenarios plus random traffic, checked by a queue-based scoreboard
// against a word-level model of the CP0 registers.
module tb_cp0;

  localparam logic [31:0] PRID_VAL = 32'h4D49_5053;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PC_M;
  logic        BD_M;
  logic [4:0]  ExcCode_M;
  logic [5:0]  HWInt;
  logic        we_M;
  logic [4:0]  addr_M;
  logic [31:0] wdata_M;
  logic        eret_M;
  logic [31:0] rdata;
  logic [31:0] EPC;
  logic        IRQ;

  cp0 #(.PRID(PRID_VAL)) dut (
    .clk       (clk),
    .reset     (reset),
    .PC_M      (PC_M),
    .BD_M      (BD_M),
    .ExcCode_M (ExcCode_M),
    .HWInt     (HWInt),
    .we_M      (we_M),
    .addr_M    (addr_M),
    .wdata_M   (wdata_M),
    .eret_M    (eret_M),
    .rdata     (rdata),
    .EPC       (EPC),
    .IRQ       (IRQ)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic        irq;
    logic [31:0] rdata;
    logic [31:0] epc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   step  = 0;

  // Reference state, held as architectural 32-bit words.
  logic [31:0] m_sr, m_cause, m_epc;

  function automatic logic model_int(input logic [5:0] hw);
    return ((({26'd0, hw} << 10) & m_sr & 32'h0000_FC00) != 0) && m_sr[0] && !m_sr[1];
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd12:   return m_sr;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      5'd15:   return PRID_VAL;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_edge(input logic rst, input logic [31:0] pc, input logic bd,
                            input logic [4:0] ec, input logic [5:0] hw, input logic we,
                            input logic [4:0] a, input logic [31:0] wd, input logic er);
    logic ir, ex;
    if (rst) begin
      m_sr = 0; m_cause = 0; m_epc = 0;
      return;
    end
    ir = model_int(hw);
    ex = (ec != 0) && !m_sr[1];
    m_cause = (m_cause & ~32'h0000_FC00) | ({26'd0, hw} << 10);
    if (ir || ex) begin
      m_sr = m_sr | 32'd2;
      m_cause = (m_cause & 32'h7FFF_FC00) | (bd ? 32'h8000_0000 : 0)
                | (ir ? 32'd0 : ({27'd0, ec} * 4));
      m_epc = (bd ? pc - 4 : pc) / 4 * 4;
    end else begin
      if (we && a == 12) m_sr = wd & 32'h0000_FC03;
      if (we && a == 14) m_epc = wd / 4 * 4;
      if (er) m_sr = m_sr & ~32'd2;
    end
  endtask

  // Apply one cycle of inputs, queue the expected outputs, then advance the model at the edge.
  task automatic drive(input logic chk, input logic rst, input logic [31:0] pc, input logic bd,
                       input logic [4:0] ec, input logic [5:0] hw, input logic we,
                       input logic [4:0] a, input logic [31:0] wd, input logic er);
    exp_t e;
    reset = rst; PC_M = pc; BD_M = bd; ExcCode_M = ec; HWInt = hw;
    we_M = we; addr_M = a; wdata_M = wd; eret_M = er;
    if (chk) begin
      e.id    = step;
      e.irq   = model_int(hw) || ((ec != 0) && !m_sr[1]);
      e.rdata = model_read(a);
      e.epc   = m_epc;
      exp_q.push_back(e);
    end
    step++;
    @(posedge clk);
    model_edge(rst, pc, bd, ec, hw, we, a, wd, er);
    #1;
  endtask

  task automatic idle(input logic [5:0] hw, input logic [4:0] a);
    drive(1, 0, 32'h3000, 0, 0, hw, 0, a, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_cmp += 3;
      if (IRQ !== e.irq) begin
        n_bad++;
        $display("FAIL irq step %0d: got %b want %b", e.id, IRQ, e.irq);
      end
      if (rdata !== e.rdata) begin
        n_bad++;
        $display("FAIL rdata step %0d addr %0d: got %h want %h", e.id, addr_M, rdata, e.rdata);
      end
      if (EPC !== e.epc) begin
        n_bad++;
        $display("FAIL epc step %0d: got %h want %h", e.id, EPC, e.epc);
      end
    end
  end

  initial begin
    logic [4:0] a;
    m_sr = 0; m_cause = 0; m_epc = 0;
    #1;
    drive(0, 1, 0, 0, 0, 6'h3F, 0, 0, 0, 0);
    // Post-reset reads with all interrupt lines high.
    idle(6'h3F, 12); idle(6'h3F, 13); idle(6'h3F, 14); idle(6'h3F, 15);
    // Hardware interrupt through IM[10]/IE.
    drive(1, 0, 32'h3000, 0, 0, 0, 1, 12, 32'h0000_0401, 0);
    drive(1, 0, 32'h3010, 0, 0, 6'h01, 0, 13, 0, 0);
    idle(0, 13); idle(0, 12);
    // Delay-slot exception from a clean SR.
    drive(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 32'h3024, 1, 5'd4, 0, 0, 12, 0, 0);
    idle(0, 13); idle(0, 14);
    // Nested exception blocked while EXL, then eret releases a pending interrupt.
    drive(1, 0, 32'h3100, 0, 5'd12, 0, 0, 12, 0, 0);
    drive(1, 0, 32'h3104, 0, 0, 6'h01, 1, 12, 32'h0000_0403, 0);
    drive(1, 0, 32'h3108, 0, 0, 6'h01, 0, 12, 0, 1);
    drive(1, 0, 32'h310C, 0, 0, 6'h01, 0, 12, 0, 0);
    idle(0, 14);
    // Priority: IRQ blocks mtc0 EPC; Cause writes ignored.
    drive(1, 0, 32'h3000, 0, 0, 0, 1, 12, 32'h0000_0401, 0);
    drive(1, 0, 32'h3200, 0, 0, 6'h01, 1, 14, 32'h0000_5000, 0);
    idle(0, 14);
    drive(1, 0, 32'h3204, 0, 0, 0, 1, 13, 32'hFFFF_FFFF, 0);
    idle(0, 13);
    // eret and mtc0 SR together, then interrupt plus exception in one cycle.
    drive(1, 0, 32'h3208, 0, 0, 0, 1, 12, 32'h0000_FC03, 1);
    idle(0, 12);
    drive(1, 0, 32'h0000_0000, 1, 5'd10, 6'h20, 0, 13, 0, 0);
    idle(0, 13); idle(0, 14);
    // Reset while in the handler.
    drive(1, 1, 0, 0, 0, 6'h3F, 0, 12, 0, 0);
    idle(6'h3F, 12);
    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 4))
        0: a = 5'd12;
        1: a = 5'd13;
        2: a = 5'd14;
        3: a = 5'd15;
        default: a = 5'($urandom);
      endcase
      drive(1, $urandom_range(0, 99) == 0, $urandom, 1'($urandom),
            ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0,
            ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0,
            $urandom_range(0, 3) == 0, a,
            ($urandom_range(0, 1) == 0) ? $urandom : ($urandom & 32'h0000_FC03),
            $urandom_range(0, 7) == 0);
    end
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
